// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: control and result bundle between the period meter and its consumer.
// The master drives start/rd_ack; the slave (meter) drives results and status.
interface clk_period_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             rd_ack;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             ovf;
    logic             busy;

    modport master (
        output start, rd_ack,
        input  period, high_time, valid, ovf, busy
    );

    modport slave (
        input  start, rd_ack,
        output period, high_time, valid, ovf, busy
    );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an async square wave in clk100 cycles.
// Define CLK_PERIOD_METER_AUTO_REARM_EN for continuous back-to-back measurement.
module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic              sig_in,
    clk_period_meter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX = '1;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_max;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi_cap;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic                   r_fall_seen;
    logic                   r_ovf;
    logic                   w_valid;
    logic                   w_busy;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_hist;
    assign w_fall = ~w_sync & r_hist;
    assign w_max  = (r_cnt == MAX);

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_hist <= w_sync;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_next = S_ARM;
            S_ARM:  if (w_rise) w_next = S_MEAS;
            S_MEAS: begin
`ifdef CLK_PERIOD_METER_AUTO_REARM_EN
                if (w_max) w_next = S_ARM;
`else
                if (w_max || w_rise) w_next = S_DONE;
`endif
            end
            S_DONE: if (bus.rd_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A rise landing on the saturated count is treated as a timeout.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_fall_seen <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                S_ARM: begin
                    if (w_rise) begin
                        r_cnt       <= '0;
                        r_fall_seen <= 1'b0;
                    end
                end
                S_MEAS: begin
                    if (w_max) begin
                        r_period <= MAX;
                        r_high   <= r_fall_seen ? r_hi_cap : MAX;
                        r_ovf    <= 1'b1;
                    end else if (w_rise) begin
                        r_period    <= r_cnt + 1'b1;
                        r_high      <= r_hi_cap;
                        r_ovf       <= 1'b0;
                        r_cnt       <= '0;
                        r_fall_seen <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                            r_hi_cap    <= r_cnt + 1'b1;
                            r_fall_seen <= 1'b1;
                        end
                    end
                end
                S_DONE: if (bus.rd_ack) r_ovf <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef CLK_PERIOD_METER_AUTO_REARM_EN
    logic r_vpulse;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) r_vpulse <= 1'b0;
        else        r_vpulse <= (r_state == S_MEAS) && (w_max || w_rise);
    end
`endif

    always_comb begin
        w_busy = (r_state == S_ARM) || (r_state == S_MEAS);
`ifdef CLK_PERIOD_METER_AUTO_REARM_EN
        w_valid = r_vpulse;
`else
        w_valid = (r_state == S_DONE);
`endif
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high;
    assign bus.ovf       = r_ovf;
    assign bus.valid     = w_valid;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized self-checking bench for clk_period_meter (CNT_W=8).
// Expected results come from the waveform parameters, saturated at the counter limit.
module tb_clk_period_meter;
    localparam int W   = 8;
    localparam int SAT = 255;

    logic clk100;
    logic rst_n;
    logic sig_in;

    clk_period_meter_if #(.CNT_W(W)) bus ();

    clk_period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    int g_mode = 0;
    int g_hi   = 1;
    int g_lo   = 1;
    int g_ph   = 0;

    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    // Waveform source: 0 = low, 1 = square wave hi/lo, 2 = held high
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk100);
            if (g_mode == 0) sig_in = 1'b0;
            else if (g_mode == 2) sig_in = 1'b1;
            else begin
                sig_in = (g_ph < g_hi);
                g_ph = (g_ph + 1 >= g_hi + g_lo) ? 0 : g_ph + 1;
            end
        end
    end

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic set_wave(input int hi, input int lo);
        g_hi = hi;
        g_lo = lo;
        g_ph = 0;
        g_mode = 1;
        tick(2 * (hi + lo) + 6);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.rd_ack = 1'b1;
        tick(1);
        bus.rd_ack = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rd_ack = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if ({bus.valid, bus.ovf, bus.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got %b exp 000", {bus.valid, bus.ovf, bus.busy});
        end
        n_checks++;
        if (bus.period !== 8'd0 || bus.high_time !== 8'd0) begin
            n_err++;
            $display("FAIL reset_results got %0d/%0d exp 0/0", bus.period, bus.high_time);
        end
    endtask

    task automatic test_basic();
        bit ok;
        set_wave(4, 4);
        pulse_start();
        wait_valid(100, ok);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_valid got timeout exp valid");
        end
        n_checks++;
        if (bus.period !== 8'd8 || bus.high_time !== 8'd4 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result got %0d/%0d/%b exp 8/4/0", bus.period, bus.high_time, bus.ovf);
        end
        tick(10);
        n_checks++;
        if (bus.valid !== 1'b1 || bus.period !== 8'd8 || bus.high_time !== 8'd4) begin
            n_err++;
            $display("FAIL basic_hold got %b %0d/%0d exp 1 8/4", bus.valid, bus.period, bus.high_time);
        end
        pulse_ack();
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ack_clear got %b exp 0", bus.valid);
        end
    endtask

    task automatic test_duty();
        bit ok;
        set_wave(3, 7);
        pulse_start();
        wait_valid(100, ok);
        n_checks++;
        if (!ok || bus.period !== 8'd10 || bus.high_time !== 8'd3) begin
            n_err++;
            $display("FAIL duty_3_10 got ok=%b %0d/%0d exp 10/3", ok, bus.period, bus.high_time);
        end
        pulse_ack();
    endtask

    task automatic test_timeout();
        bit ok;
        g_mode = 0;
        tick(6);
        pulse_start();
        tick(4);
        g_mode = 2;
        wait_valid(400, ok);
        n_checks++;
        if (!ok || bus.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_ovf got ok=%b ovf=%b exp ovf 1", ok, bus.ovf);
        end
        n_checks++;
        if (bus.period !== 8'd255 || bus.high_time !== 8'd255) begin
            n_err++;
            $display("FAIL timeout_result got %0d/%0d exp 255/255", bus.period, bus.high_time);
        end
        pulse_ack();
        n_checks++;
        if (bus.valid !== 1'b0 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_ack got v=%b o=%b exp 0 0", bus.valid, bus.ovf);
        end
        g_mode = 0;
        tick(4);
    endtask

    task automatic test_start_ignored();
        bit ok;
        set_wave(4, 6);
        pulse_start();
        tick(12);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL ign_busy got %b exp 1", bus.busy);
        end
        pulse_start();
        wait_valid(100, ok);
        n_checks++;
        if (!ok || bus.period !== 8'd10 || bus.high_time !== 8'd4) begin
            n_err++;
            $display("FAIL ign_meas got ok=%b %0d/%0d exp 10/4", ok, bus.period, bus.high_time);
        end
        pulse_start();
        tick(15);
        n_checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.period !== 8'd10) begin
            n_err++;
            $display("FAIL ign_done got v=%b b=%b p=%0d exp 1 0 10", bus.valid, bus.busy, bus.period);
        end
        bus.start = 1'b1;
        bus.rd_ack = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.rd_ack = 1'b0;
        tick(30);
        n_checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ign_single got v=%b b=%b exp 0 0", bus.valid, bus.busy);
        end
    endtask

    task automatic test_boundary();
        int tbl_hi[2] = '{100, 128};
        int tbl_lo[2] = '{155, 128};
        bit ok;
        for (int k = 0; k < 2; k++) begin
            int n;
            n = tbl_hi[k] + tbl_lo[k];
            set_wave(tbl_hi[k], tbl_lo[k]);
            pulse_start();
            wait_valid(800, ok);
            n_checks++;
            if (!ok || bus.period !== sat(n) || bus.high_time !== sat(tbl_hi[k]) ||
                bus.ovf !== (n > SAT)) begin
                n_err++;
                $display("FAIL boundary_%0d got %0d/%0d/%b exp %0d/%0d/%b", n, bus.period,
                         bus.high_time, bus.ovf, sat(n), sat(tbl_hi[k]), (n > SAT));
            end
            pulse_ack();
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int k = 0; k < 8; k++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 150);
            lo = $urandom_range(1, 150);
            set_wave(hi, lo);
            pulse_start();
            wait_valid(800, ok);
            n_checks++;
            if (!ok || bus.period !== sat(hi + lo) || bus.high_time !== sat(hi) ||
                bus.ovf !== (hi + lo > SAT)) begin
                n_err++;
                $display("FAIL random_%0d_%0d got ok=%b %0d/%0d/%b exp %0d/%0d/%b", hi, lo, ok,
                         bus.period, bus.high_time, bus.ovf, sat(hi + lo), sat(hi), (hi + lo > SAT));
            end
            pulse_ack();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_wave(20, 20);
        pulse_start();
        tick(50);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy got %b exp 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.period !== 8'd0 || bus.high_time !== 8'd0 ||
            {bus.valid, bus.ovf, bus.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset got %0d/%0d %b exp 0/0 000", bus.period, bus.high_time,
                     {bus.valid, bus.ovf, bus.busy});
        end
        tick(3);
        rst_n = 1'b1;
        set_wave(3, 3);
        pulse_start();
        wait_valid(100, ok);
        n_checks++;
        if (!ok || bus.period !== 8'd6 || bus.high_time !== 8'd3 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL mid_after got ok=%b %0d/%0d/%b exp 6/3/0", ok, bus.period,
                     bus.high_time, bus.ovf);
        end
        pulse_ack();
    endtask

`ifdef CLK_PERIOD_METER_AUTO_REARM_EN
    task automatic test_auto_rearm();
        bit ok;
        set_wave(5, 7);
        pulse_start();
        wait_valid(200, ok);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL auto_first got timeout exp valid");
        end
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = 0;
            tick(1);
            gap = 1;
            while (bus.valid !== 1'b1 && gap < 40) begin
                tick(1);
                gap++;
            end
            n_checks++;
            if (gap !== 12 || bus.period !== 8'd12 || bus.high_time !== 8'd5 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL auto_pulse_%0d got gap=%0d %0d/%0d b=%b exp 12 12/5 1", k, gap,
                         bus.period, bus.high_time, bus.busy);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rd_ack = 1'b0;
        test_reset();
`ifdef CLK_PERIOD_METER_AUTO_REARM_EN
        test_auto_rearm();
`else
        test_basic();
        test_duty();
        test_timeout();
        test_start_ignored();
        test_boundary();
        test_random();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
